// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath (add/sub/and, addi, lw,
// sw, beq, j). Control outputs are registered: the decode of the next state is
// captured on the same edge that loads the state register, so every output is
// always the pure decode of the current state with no combinational path from
// opcode/funct to the datapath controls.
// state_dbg encoding: 0 RESET, 1 FETCH1, 2 FETCH2, 3 FETCH3, 4 DECODE,
// 5 R_EXEC, 6 R_WB, 7 ADDI_EXEC, 8 ADDI_WB, 9 MEM_ADDR, 10 MEM_RD1, 11 MEM_RD2,
// 12 LW_WB, 13 SW_WRITE, 14 BRANCH, 15 JUMP, 16 EXCEPT.
module multicycle_control_fsm #(
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               ALUSrcA,
  output logic [2:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               IorD,
  output logic               MemWR,
  output logic               IRWrite,
  output logic               MDRWrite,
  output logic               ABWrite,
  output logic               ALUOutWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               exception,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 5'd0,
    S_FETCH1    = 5'd1,
    S_FETCH2    = 5'd2,
    S_FETCH3    = 5'd3,
    S_DECODE    = 5'd4,
    S_R_EXEC    = 5'd5,
    S_R_WB      = 5'd6,
    S_ADDI_EXEC = 5'd7,
    S_ADDI_WB   = 5'd8,
    S_MEM_ADDR  = 5'd9,
    S_MEM_RD1   = 5'd10,
    S_MEM_RD2   = 5'd11,
    S_LW_WB     = 5'd12,
    S_SW_WRITE  = 5'd13,
    S_BRANCH    = 5'd14,
    S_JUMP      = 5'd15,
    S_EXCEPT    = 5'd16
  } state_t;

  typedef struct packed {
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [2:0] aluop;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memwr;
    logic       irwrite;
    logic       mdrwrite;
    logic       abwrite;
    logic       aluoutwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       exception;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  state_t state_r;
  state_t state_next_s;
  ctrl_t  ctrl_r;

  // The branch outcome is resolved in the datapath (PCWriteCond AND zero).
  logic   zero_unused_s;
  assign zero_unused_s = zero;

  // Control decode of one state; funct only matters in R_EXEC.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH1, S_FETCH2: begin
        c.iord  = 1'b0;
        c.memwr = 1'b0;
      end
      S_FETCH3: begin
        c.irwrite  = 1'b1;
        c.alusrca  = 1'b0;
        c.alusrcb  = 3'd1;
        c.aluop    = ALU_ADD;
        c.pcsource = 2'd0;
        c.pcwrite  = 1'b1;
      end
      S_DECODE: begin
        c.abwrite     = 1'b1;
        c.alusrca     = 1'b0;
        c.alusrcb     = 3'd2;
        c.aluop       = ALU_ADD;
        c.aluoutwrite = 1'b1;
      end
      S_R_EXEC: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = 3'd0;
        c.aluoutwrite = 1'b1;
        case (fn)
          FN_SUB:  c.aluop = ALU_SUB;
          FN_AND:  c.aluop = ALU_AND;
          default: c.aluop = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        c.memtoreg = 1'b0;
      end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = 3'd3;
        c.aluop       = ALU_ADD;
        c.aluoutwrite = 1'b1;
      end
      S_ADDI_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b0;
        c.memtoreg = 1'b0;
      end
      S_MEM_RD1: c.iord = 1'b1;
      S_MEM_RD2: begin
        c.iord     = 1'b1;
        c.mdrwrite = 1'b1;
      end
      S_LW_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b0;
        c.memtoreg = 1'b1;
      end
      S_SW_WRITE: begin
        c.iord  = 1'b1;
        c.memwr = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = 3'd0;
        c.aluop       = ALU_SUB;
        c.pcsource    = 2'd1;
        c.pcwritecond = 1'b1;
      end
      S_JUMP: begin
        c.pcsource = 2'd2;
        c.pcwrite  = 1'b1;
      end
      S_EXCEPT: c.exception = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; opcode/funct are only looked at in DECODE and MEM_ADDR.
  always_comb begin
    state_next_s = S_RESET;
    case (state_r)
      S_RESET:     state_next_s = S_FETCH1;
      S_FETCH1:    state_next_s = S_FETCH2;
      S_FETCH2:    state_next_s = S_FETCH3;
      S_FETCH3:    state_next_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND)) begin
              state_next_s = S_R_EXEC;
            end else begin
              state_next_s = S_EXCEPT;
            end
          end
          OP_ADDI:       state_next_s = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_next_s = S_MEM_ADDR;
          OP_BEQ:        state_next_s = S_BRANCH;
          OP_JUMP:       state_next_s = S_JUMP;
          default:       state_next_s = S_EXCEPT;
        endcase
      end
      S_R_EXEC:    state_next_s = S_R_WB;
      S_R_WB:      state_next_s = S_FETCH1;
      S_ADDI_EXEC: state_next_s = S_ADDI_WB;
      S_ADDI_WB:   state_next_s = S_FETCH1;
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          state_next_s = S_MEM_RD1;
        end else begin
          state_next_s = S_SW_WRITE;
        end
      end
      S_MEM_RD1:   state_next_s = S_MEM_RD2;
      S_MEM_RD2:   state_next_s = S_LW_WB;
      S_LW_WB:     state_next_s = S_FETCH1;
      S_SW_WRITE:  state_next_s = S_FETCH1;
      S_BRANCH:    state_next_s = S_FETCH1;
      S_JUMP:      state_next_s = S_FETCH1;
      S_EXCEPT:    state_next_s = S_EXCEPT;
      default:     state_next_s = S_RESET;
    endcase
  end

  // State register plus registered decode of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_RESET;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= decode_ctrl(state_next_s, funct);
    end
  end

  assign ALUSrcA     = ctrl_r.alusrca;
  assign ALUSrcB     = ctrl_r.alusrcb;
  assign ALUOp       = ctrl_r.aluop;
  assign PCWrite     = ctrl_r.pcwrite;
  assign PCWriteCond = ctrl_r.pcwritecond;
  assign PCSource    = ctrl_r.pcsource;
  assign IorD        = ctrl_r.iord;
  assign MemWR       = ctrl_r.memwr;
  assign IRWrite     = ctrl_r.irwrite;
  assign MDRWrite    = ctrl_r.mdrwrite;
  assign ABWrite     = ctrl_r.abwrite;
  assign ALUOutWrite = ctrl_r.aluoutwrite;
  assign RegWrite    = ctrl_r.regwrite;
  assign RegDst      = ctrl_r.regdst;
  assign MemToReg    = ctrl_r.memtoreg;
  assign exception   = ctrl_r.exception;
  assign state_dbg   = state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle and compares the state and full control word against
// hand-written per-state expectations.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       PCWrite, PCWriteCond;
  logic [1:0] PCSource;
  logic       IorD, MemWR, IRWrite, MDRWrite, ABWrite, ALUOutWrite;
  logic       RegWrite, RegDst, MemToReg, exception;
  logic [4:0] state_dbg;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.STATE_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD), .MemWR(MemWR),
    .IRWrite(IRWrite), .MDRWrite(MDRWrite), .ABWrite(ABWrite),
    .ALUOutWrite(ALUOutWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .exception(exception), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Control word order: ALUSrcA, ALUSrcB, ALUOp, PCWrite, PCWriteCond, PCSource,
  // IorD, MemWR, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite, RegDst,
  // MemToReg, exception
  logic [20:0] obs;
  assign obs = {ALUSrcA, ALUSrcB, ALUOp, PCWrite, PCWriteCond, PCSource, IorD, MemWR,
                IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite, RegDst, MemToReg, exception};

  localparam logic [20:0] C_ZERO = 21'h0;
  localparam logic [20:0] C_F3   = {1'b0, 3'd1, 3'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_DEC  = {1'b0, 3'd2, 3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_RADD = {1'b1, 3'd0, 3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_RSUB = {1'b1, 3'd0, 3'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_RAND = {1'b1, 3'd0, 3'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_RWB  = {1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] C_IMM  = {1'b1, 3'd3, 3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_IWB  = {1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_RD1  = {1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_RD2  = {1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_LWB  = {1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [20:0] C_SW   = {1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_BR   = {1'b1, 3'd0, 3'd2, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_J    = {1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] C_EXC  = 21'h1;

  localparam logic [4:0] S_RST = 5'd0,  S_F1 = 5'd1,  S_F2 = 5'd2,  S_F3 = 5'd3;
  localparam logic [4:0] S_DEC = 5'd4,  S_REX = 5'd5, S_RWB = 5'd6, S_IEX = 5'd7;
  localparam logic [4:0] S_IWB = 5'd8,  S_MAD = 5'd9, S_RD1 = 5'd10, S_RD2 = 5'd11;
  localparam logic [4:0] S_LWB = 5'd12, S_SW = 5'd13, S_BR = 5'd14, S_J = 5'd15;
  localparam logic [4:0] S_EXC = 5'd16;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state_dbg !== S_RST || obs !== C_ZERO) begin
        errors++;
        $display("FAIL reset cyc%0d: got state=%0d ctrl=%h want state=%0d ctrl=%h", i, state_dbg, obs, S_RST, C_ZERO);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (state_dbg !== S_F1 || obs !== C_ZERO) begin
      errors++;
      $display("FAIL reset_release: got state=%0d ctrl=%h want state=%0d ctrl=%h", state_dbg, obs, S_F1, C_ZERO);
    end
  endtask

  task automatic test_r_type();
    logic [5:0]  fn [3];
    logic [20:0] ex [3];
    logic [4:0]  se [6];
    logic [20:0] ce [6];
    fn = '{6'h20, 6'h22, 6'h24};
    ex = '{C_RADD, C_RSUB, C_RAND};
    for (int k = 0; k < 3; k++) begin
      se = '{S_F1, S_F2, S_F3, S_DEC, S_REX, S_RWB};
      ce = '{C_ZERO, C_ZERO, C_F3, C_DEC, ex[k], C_RWB};
      opcode = 6'h00;
      funct  = fn[k];
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (state_dbg !== se[i] || obs !== ce[i]) begin
          errors++;
          $display("FAIL rtype fn=%h cyc%0d: got state=%0d ctrl=%h want state=%0d ctrl=%h", fn[k], i, state_dbg, obs, se[i], ce[i]);
        end
        tick();
      end
      checks++;
      if (state_dbg !== S_F1) begin
        errors++;
        $display("FAIL rtype_latency fn=%h: got state=%0d want %0d", fn[k], state_dbg, S_F1);
      end
    end
  endtask

  task automatic test_addi();
    logic [4:0]  se [6];
    logic [20:0] ce [6];
    se = '{S_F1, S_F2, S_F3, S_DEC, S_IEX, S_IWB};
    ce = '{C_ZERO, C_ZERO, C_F3, C_DEC, C_IMM, C_IWB};
    opcode = 6'h08;
    funct  = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state_dbg !== se[i] || obs !== ce[i]) begin
        errors++;
        $display("FAIL addi cyc%0d: got state=%0d ctrl=%h want state=%0d ctrl=%h", i, state_dbg, obs, se[i], ce[i]);
      end
      tick();
    end
    checks++;
    if (state_dbg !== S_F1) begin
      errors++;
      $display("FAIL addi_latency: got state=%0d want %0d", state_dbg, S_F1);
    end
  endtask

  task automatic test_lw();
    logic [4:0]  se [8];
    logic [20:0] ce [8];
    se = '{S_F1, S_F2, S_F3, S_DEC, S_MAD, S_RD1, S_RD2, S_LWB};
    ce = '{C_ZERO, C_ZERO, C_F3, C_DEC, C_IMM, C_RD1, C_RD2, C_LWB};
    opcode = 6'h23;
    funct  = 6'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (state_dbg !== se[i] || obs !== ce[i]) begin
        errors++;
        $display("FAIL lw cyc%0d: got state=%0d ctrl=%h want state=%0d ctrl=%h", i, state_dbg, obs, se[i], ce[i]);
      end
      tick();
    end
    checks++;
    if (state_dbg !== S_F1) begin
      errors++;
      $display("FAIL lw_latency: got state=%0d want %0d", state_dbg, S_F1);
    end
  endtask

  task automatic test_sw();
    logic [4:0]  se [6];
    logic [20:0] ce [6];
    se = '{S_F1, S_F2, S_F3, S_DEC, S_MAD, S_SW};
    ce = '{C_ZERO, C_ZERO, C_F3, C_DEC, C_IMM, C_SW};
    opcode = 6'h2B;
    funct  = 6'h20;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state_dbg !== se[i] || obs !== ce[i]) begin
        errors++;
        $display("FAIL sw cyc%0d: got state=%0d ctrl=%h want state=%0d ctrl=%h", i, state_dbg, obs, se[i], ce[i]);
      end
      tick();
    end
    checks++;
    if (state_dbg !== S_F1 || MemWR !== 1'b0) begin
      errors++;
      $display("FAIL sw_latency: got state=%0d MemWR=%b want state=%0d MemWR=0", state_dbg, MemWR, S_F1);
    end
  endtask

  task automatic test_branch_jump();
    logic [4:0]  se [5];
    logic [20:0] ce [5];
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        se = '{S_F1, S_F2, S_F3, S_DEC, S_BR};
        ce = '{C_ZERO, C_ZERO, C_F3, C_DEC, C_BR};
        opcode = 6'h04;
        zero   = (k == 0) ? 1'b1 : 1'b0;
      end else begin
        se = '{S_F1, S_F2, S_F3, S_DEC, S_J};
        ce = '{C_ZERO, C_ZERO, C_F3, C_DEC, C_J};
        opcode = 6'h02;
        zero   = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (state_dbg !== se[i] || obs !== ce[i]) begin
          errors++;
          $display("FAIL br_j op=%h zero=%b cyc%0d: got state=%0d ctrl=%h want state=%0d ctrl=%h", opcode, zero, i, state_dbg, obs, se[i], ce[i]);
        end
        tick();
      end
      checks++;
      if (state_dbg !== S_F1) begin
        errors++;
        $display("FAIL br_j_latency op=%h: got state=%0d want %0d", opcode, state_dbg, S_F1);
      end
    end
  endtask

  task automatic test_reset_mid_lw();
    opcode = 6'h23;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (state_dbg !== S_RD1 || IorD !== 1'b1) begin
      errors++;
      $display("FAIL midlw_setup: got state=%0d IorD=%b want state=%0d IorD=1", state_dbg, IorD, S_RD1);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state_dbg !== S_RST || obs !== C_ZERO) begin
        errors++;
        $display("FAIL midlw_reset cyc%0d: got state=%0d ctrl=%h want state=%0d ctrl=%h", i, state_dbg, obs, S_RST, C_ZERO);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (state_dbg !== S_F1 || obs !== C_ZERO) begin
      errors++;
      $display("FAIL midlw_release: got state=%0d ctrl=%h want state=%0d ctrl=%h", state_dbg, obs, S_F1, C_ZERO);
    end
  endtask

  task automatic test_exception();
    logic [5:0]  ops [2];
    logic [5:0]  fns [2];
    logic [4:0]  se [9];
    logic [20:0] ce [9];
    ops = '{6'h3F, 6'h00};
    fns = '{6'h20, 6'h18};
    se  = '{S_F1, S_F2, S_F3, S_DEC, S_EXC, S_EXC, S_EXC, S_EXC, S_EXC};
    ce  = '{C_ZERO, C_ZERO, C_F3, C_DEC, C_EXC, C_EXC, C_EXC, C_EXC, C_EXC};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      funct  = fns[k];
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (state_dbg !== se[i] || obs !== ce[i]) begin
          errors++;
          $display("FAIL except op=%h fn=%h cyc%0d: got state=%0d ctrl=%h want state=%0d ctrl=%h", ops[k], fns[k], i, state_dbg, obs, se[i], ce[i]);
        end
        if (i < 8) tick();
      end
      reset = 1'b1;
      tick();
      checks++;
      if (state_dbg !== S_RST || obs !== C_ZERO) begin
        errors++;
        $display("FAIL except_reset: got state=%0d ctrl=%h want state=%0d ctrl=%h", state_dbg, obs, S_RST, C_ZERO);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (state_dbg !== S_F1) begin
        errors++;
        $display("FAIL except_release: got state=%0d want %0d", state_dbg, S_F1);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_r_type();
    test_addi();
    test_lw();
    test_sw();
    test_branch_jump();
    test_reset_mid_lw();
    test_exception();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
